uart_tx_framed: RTL and testbench

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

---
 rtl/uart_tx_framed.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_framed.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framed.sv
// uart_tx_framed: framed UART transmitter (start, DATA_BITS data LSB first, optional parity, STOP_BITS stop); parity support is compiled in with `define UART_TX_PARITY_EN
module uart_tx_framed #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick_1x,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]           parity_mode,
`endif
    output logic                 tx_line,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 stop_q, stop_d;
    logic                 line_q, line_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic [1:0]           mode_q, mode_d;
    logic                 par_on, par_bit;

    // 01 and 10 enable parity; odd mode (10) inverts the even XOR
    assign par_on  = ^mode_q;
    assign par_bit = (^data_q) ^ mode_q[1];
`endif

    assign tx_ready = (state_q == IDLE);
    assign tx_line  = line_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

    // Next-state and output logic; each state advances only on a baud tick
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        line_d  = line_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = ARM;
                    data_d  = tx_data;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    mode_d  = parity_mode;
`endif
                end
            end
            ARM: begin
                if (baud_tick_1x) begin
                    line_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick_1x) begin
                    line_d  = data_q[0];
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick_1x) begin
                    if (cnt_q != LAST_BIT) begin
                        line_d = data_q[cnt_q + CW'(1)];
                        cnt_d  = cnt_q + CW'(1);
                    end else begin
                        line_d  = 1'b1;
                        stop_d  = 1'b0;
                        state_d = STOP;
`ifdef UART_TX_PARITY_EN
                        if (par_on) begin
                            line_d  = par_bit;
                            state_d = PARITY;
                        end
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick_1x) begin
                    line_d  = 1'b1;
                    stop_d  = 1'b0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick_1x) begin
                    if (stop_q == LAST_STOP) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset that aborts any frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            mode_q  <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            mode_q  <= mode_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_framed.sv
// tb_uart_tx_framed: scoreboard bench for uart_tx_framed against a frame-level bit-list model
module tb_uart_tx_framed;
    localparam int DB = 8;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] bits;
        int          n;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst_n, baud_tick_1x, tx_valid, tx_ready, tx_line, tx_busy, tx_done;
    logic [DB-1:0] tx_data;
`ifdef UART_TX_PARITY_EN
    logic [1:0]    parity_mode;
`endif
    logic          valid2, ready2, line2, busy2, done2;
    logic [4:0]    data2;

    int     checks = 0;
    int     errors = 0;
    int     exp_frames = 0;
    int     frames_done = 0;
    bit     random_ticks = 1'b0;
    bit     mon_active = 1'b0;
    frame_t sb[$];

    always #5 clk = ~clk;

    uart_tx_framed #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .baud_tick_1x(baud_tick_1x),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
`ifdef UART_TX_PARITY_EN
        .parity_mode(parity_mode),
`endif
        .tx_line(tx_line),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    uart_tx_framed #(.DATA_BITS(5), .STOP_BITS(2)) dut2 (
        .clk(clk),
        .rst_n(rst_n),
        .baud_tick_1x(baud_tick_1x),
        .tx_valid(valid2),
        .tx_ready(ready2),
        .tx_data(data2),
`ifdef UART_TX_PARITY_EN
        .parity_mode(2'b00),
`endif
        .tx_line(line2),
        .tx_busy(busy2),
        .tx_done(done2)
    );

    // Expected line value after each tick of a frame, plus total tick count
    function automatic frame_t mk(input logic [DB-1:0] d, input logic [1:0] m);
        frame_t f;
        int     k;
        bit     par;
        par = PAR_EN && (m == 2'b01 || m == 2'b10);
        f.bits = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) f.bits[1 + i] = d[i];
        k = 1 + DB;
        if (par) begin
            f.bits[k] = (^d) ^ (m == 2'b10);
            k++;
        end
        for (int s = 0; s < SB; s++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.n = k + 1;
        return f;
    endfunction

    // Baud tick: fixed 16-cycle period, or random gaps (incl. back-to-back and long stalls)
    initial begin
        int tc;
        tc = 0;
        baud_tick_1x = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tc == 0) begin
                baud_tick_1x = 1'b1;
                tc = random_ticks ? int'($urandom_range(0, 30)) : 15;
            end else begin
                baud_tick_1x = 1'b0;
                tc--;
            end
        end
    end

    // Monitor: checks outputs each cycle against the model, then predicts the next edge
    initial begin
        frame_t cur;
        int     tk;
        bit     armed;
        logic   e_line, e_busy, e_done;
        armed = 1'b0;
        tk = 0;
        e_line = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        cur.bits = '0;
        cur.n = 0;
        forever begin
            @(negedge clk);
            if (armed) begin
                checks++;
                if (tx_line !== e_line || tx_busy !== e_busy || tx_done !== e_done || tx_ready !== !e_busy) begin
                    errors++;
                    $display("FAIL cycle @%0t: line=%b busy=%b done=%b ready=%b, expected line=%b busy=%b done=%b ready=%b",
                             $time, tx_line, tx_busy, tx_done, tx_ready, e_line, e_busy, e_done, !e_busy);
                end
            end
            armed = 1'b1;
            if (!rst_n) begin
                mon_active = 1'b0;
                e_line = 1'b1;
                e_busy = 1'b0;
                e_done = 1'b0;
            end else if (!mon_active && tx_valid) begin
                e_done = 1'b0;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL accept @%0t: got acceptance, expected no queued frame", $time);
                end else begin
                    cur = sb.pop_front();
                    mon_active = 1'b1;
                    tk = 0;
                    e_line = 1'b1;
                    e_busy = 1'b1;
                end
            end else if (mon_active && baud_tick_1x) begin
                tk++;
                if (tk == cur.n) begin
                    mon_active = 1'b0;
                    e_line = 1'b1;
                    e_busy = 1'b0;
                    e_done = 1'b1;
                    frames_done++;
                end else begin
                    e_line = cur.bits[tk-1];
                    e_busy = 1'b1;
                    e_done = 1'b0;
                end
            end else begin
                e_done = 1'b0;
                e_busy = mon_active;
                if (!mon_active) e_line = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [DB-1:0] d, input logic [1:0] m, input bit hold, output bit tk, output int waited);
        sb.push_back(mk(d, m));
        exp_frames++;
        tx_data = d;
`ifdef UART_TX_PARITY_EN
        parity_mode = m;
`endif
        tx_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!tx_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        tk = baud_tick_1x;
        if (waited >= 3000) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: waited %0d cycles, expected acceptance", waited);
        end
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
        tx_data = DB'($urandom);
`ifdef UART_TX_PARITY_EN
        parity_mode = 2'($urandom);
`endif
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((tx_busy || mon_active || sb.size() != 0) && w < 6000) begin
            @(negedge clk);
            w++;
        end
        chk("idle_timeout", 32'(w >= 6000), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int w;
        w = 0;
        @(negedge clk);
        while (!baud_tick_1x && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("tick_timeout", 32'(baud_tick_1x), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        bit            tk;
        int            waited, n;
        logic [DB-1:0] d;
        logic [1:0]    m;
        logic [7:0]    e2;
        bit            hold;
        rst_n = 1'b0;
        tx_valid = 1'b0;
        tx_data = '0;
`ifdef UART_TX_PARITY_EN
        parity_mode = 2'b00;
`endif
        valid2 = 1'b0;
        data2 = '0;
        repeat (2) @(negedge clk);
        chk("reset_line", 32'(tx_line), 32'd1);
        chk("reset_busy", 32'(tx_busy), 32'd0);
        chk("reset_done", 32'(tx_done), 32'd0);
        chk("reset_ready", 32'(tx_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(8'h55, 2'b00, 1'b0, tk, waited);
        wait_idle();
`ifdef UART_TX_PARITY_EN
        send(8'h07, 2'b01, 1'b0, tk, waited);
        wait_idle();
        send(8'h07, 2'b10, 1'b0, tk, waited);
        wait_idle();
`endif
        n = 0;
        @(negedge clk);
        while (!baud_tick_1x && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (16) @(posedge clk);
        #1;
        send(8'hC3, 2'b00, 1'b0, tk, waited);
        chk("tick_at_accept", 32'(tk), 32'd1);
        wait_idle();

        send(8'hA5, 2'b00, 1'b1, tk, waited);
        send(8'h3C, 2'b00, 1'b0, tk, waited);
        wait_idle();

        data2 = 5'h1F;
        valid2 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        valid2 = 1'b0;
        data2 = 5'h00;
        e2 = 8'hFE;
        for (int k = 1; k <= 8; k++) begin
            wait_tick();
            chk($sformatf("db5_line_t%0d", k), 32'(line2), 32'(e2[k-1]));
            chk($sformatf("db5_busy_t%0d", k), {30'd0, busy2, done2}, 32'd2);
        end
        wait_tick();
        chk("db5_end", {29'd0, line2, busy2, done2}, 32'd5);
        @(negedge clk);
        chk("db5_done_pulse", 32'(done2), 32'd0);
        @(posedge clk);
        #1;

        random_ticks = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d = DB'($urandom);
            m = 2'($urandom);
            hold = ($urandom_range(0, 2) == 0) && (i != 39);
            send(d, m, hold, tk, waited);
            if (!hold && $urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();
        random_ticks = 1'b0;

        send(8'hFF, 2'b00, 1'b0, tk, waited);
        n = 0;
        while (n < 5) begin
            @(negedge clk);
            if (baud_tick_1x) n++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_frames--;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_line", 32'(tx_line), 32'd1);
        chk("abort_busy", 32'(tx_busy), 32'd0);
        send(8'h00, 2'b00, 1'b0, tk, waited);
        chk("accept_after_reset", 32'(waited), 32'd0);
        wait_idle();

        chk("frames_completed", 32'(frames_done), 32'(exp_frames));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
